instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/nn_isa_pkg.sv | 41 ++++
 rtl/instr_buf.sv | 60 ++++++
 rtl/instr_fetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/nn_isa_pkg.sv
// nn_isa_pkg: shared instruction-set definitions for the fetch and control
// stages. It holds the opcode constants, the bit positions of the instruction
// fields, the fetch FSM state type, and a helper that sorts opcodes into
// those that go to decode and those that stop fetch.
package nn_isa_pkg;

    localparam int INSTR_W = 16;

    // Opcodes. Any opcode in the range 5..D is illegal.
    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_SINN = 4'h3;
    localparam logic [3:0] OP_MAC  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'hE;
    localparam logic [3:0] OP_ST   = 4'hF;

    // Field positions: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/offset.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 8;
    localparam int RS_MSB     = 7;
    localparam int RS_LSB     = 4;
    localparam int RT_MSB     = 3;
    localparam int RT_LSB     = 0;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_DRAIN,
        FETCH_HALT
    } fetch_state_t;

    // Returns 1 for opcodes that are forwarded to decode. HALT and the
    // illegal range both return 0, and both stop fetching.
    function automatic logic is_exec_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_MUL, OP_SINN, OP_MAC, OP_LD, OP_ST};
    endfunction

endpackage

// File: rtl/instr_buf.sv
// instr_buf: a synchronous FIFO with DEPTH entries, where DEPTH is a power
// of two and at least 2.
//   clk, reset   : clock and synchronous active-high reset
//   push/push_data : write one entry. The caller may push while full only
//                    if it pops in the same cycle.
//   pop          : remove the head entry. A pop while empty is ignored.
//   head         : current head entry, valid while empty=0
//   full, empty, count : occupancy status
module instr_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign head   = slots[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and process order cannot change the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset. Stale slots are
    // never observable because the pointers and count are reset.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit. It fetches sequentially from start_pc
// and keeps at most one memory read in flight. Executable instructions are
// placed in a DEPTH-entry buffer for the decode stage. Fetch stops at a HALT
// word or an illegal opcode, and the buffer then drains.
//   clk, reset            : clock and synchronous active-high reset
//   start, start_pc       : launch fetch. Honoured only in IDLE and HALT.
//   imem_req, imem_addr   : one-cycle read request and its address
//   imem_rvalid, imem_rdata : in-order read response, 1 or more cycles later
//   out_valid, out_ready  : head-of-buffer handshake toward decode
//   opcode, rd, rs, rt, pc_out : fields and address of the head instruction
//   halted                : fetch has stopped and the buffer is empty
//   illegal               : sticky flag, set when an illegal opcode is fetched
//                           after the most recent start
module instr_fetch
    import nn_isa_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted,
    output logic               illegal
);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = PC_W + INSTR_W;

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     req_pc;       // address of the request in flight
    logic                outstanding;
    logic                start_accept;
    logic                resp;
    logic [3:0]          resp_op;
    logic                resp_exec;
    logic                resp_stop;
    logic                resp_illegal;
    logic                pop;
    logic                buf_push;
    logic                buf_full;
    logic                buf_empty;
    logic [CW-1:0]       buf_count;
    logic [CW-1:0]       post_count;
    logic [ENTRY_W-1:0]  head;
    logic [INSTR_W-1:0]  head_instr;

    // A response is used only while a request is in flight. Any stray
    // rvalid, including one that arrives after reset, is dropped here.
    assign resp         = outstanding && imem_rvalid;
    assign resp_op      = imem_rdata[OPCODE_MSB:OPCODE_LSB];
    assign resp_exec    = resp && is_exec_op(resp_op);
    assign resp_stop    = resp && !is_exec_op(resp_op);
    assign resp_illegal = resp_stop && (resp_op != OP_HALT);
    assign start_accept = start && (state == FETCH_IDLE || state == FETCH_HALT);
    assign pop          = out_valid && out_ready;
    assign buf_push     = resp_exec && (!buf_full || pop);

    // Occupancy after this cycle's push and pop. A new request is issued only
    // while this is below DEPTH, so the reply always has a free slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        post_count = buf_count;
        if (buf_push && !pop)      post_count = buf_count + 1'b1;
        else if (!buf_push && pop) post_count = buf_count - 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH_IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE, FETCH_HALT: if (start)     state_next = FETCH_RUN;
            FETCH_RUN:              if (resp_stop) state_next = FETCH_DRAIN;
            FETCH_DRAIN:            if (buf_empty) state_next = FETCH_HALT;
            default:                state_next = FETCH_IDLE;
        endcase
    end

    // FSM outputs. A request is allowed in the same cycle a reply arrives,
    // unless that reply stops fetch.
    always_comb begin
        halted   = (state == FETCH_HALT);
        imem_req = (state == FETCH_RUN) && (!outstanding || imem_rvalid) &&
                   !resp_stop && (post_count < CW'(DEPTH));
    end

    assign imem_addr = pc;

    // Program counter, in-flight tracking and the sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            req_pc      <= '0;
            outstanding <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            if (start_accept) begin
                pc      <= start_pc;
                illegal <= 1'b0;
            end else if (imem_req) begin
                pc     <= pc + 1'b1;
                req_pc <= pc;
            end
            if (imem_req)  outstanding <= 1'b1;
            else if (resp) outstanding <= 1'b0;
            if (resp_illegal) illegal <= 1'b1;
        end
    end

    instr_buf #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // The head fields read as zero while the buffer is empty, so the outputs
    // are clean after reset and stale slots never appear.
    assign out_valid            = !buf_empty;
    assign {pc_out, head_instr} = out_valid ? head : '0;
    assign opcode               = head_instr[OPCODE_MSB:OPCODE_LSB];
    assign rd                   = head_instr[RD_MSB:RD_LSB];
    assign rs                   = head_instr[RS_MSB:RS_LSB];
    assign rt                   = head_instr[RT_MSB:RT_LSB];

endmodule
